// File: rtl/dff_reg.sv
// Parameterised D register / delay line with async clear and a fill-valid flag.
// Optional clock enable: define DFF_REG_ENABLE_EN to add the `en` port.
module dff_reg #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DFF_REG_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int            CW   = $clog2(STAGES + 1);
  localparam logic [CW-1:0] LAST = CW'(STAGES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] stage_r [STAGES];
  logic [CW-1:0]    cnt_r;
  logic             valid_r;
  logic             step_s;

  // Select whether this edge advances the chain.
  always_comb begin
    step_s = 1'b0;
`ifdef DFF_REG_ENABLE_EN
    if (en) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
`else
    step_s = 1'b1;
`endif
  end

  // Shift chain: stage 0 captures d, later stages follow their predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else if (step_s) begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Fill counter; valid is registered so it rises with the first delivered data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else if (step_s && !valid_r) begin
      cnt_r   <= cnt_r + ONE;
      valid_r <= (cnt_r == LAST);
    end
  end

  assign q       = stage_r[STAGES-1];
  assign q_valid = valid_r;

endmodule

// File: tb/tb_dff_reg.sv
// Directed self-checking bench for dff_reg: default 1-bit/1-stage instance
// plus an 8-bit/3-stage instance with a non-zero reset value.
module tb_dff_reg;

  logic       clk;
  logic       rst;
  logic       d0;
  logic       q0;
  logic       v0;
  logic [7:0] d1;
  logic [7:0] q1;
  logic       v1;
  logic       en0;
  logic       en1;
  int         total;
  int         bad;

  dff_reg u0 (
    .clk(clk), .rst(rst),
`ifdef DFF_REG_ENABLE_EN
    .en(en0),
`endif
    .d(d0), .q(q0), .q_valid(v0)
  );

  dff_reg #(.WIDTH(8), .STAGES(3), .RST_VAL(8'hA5)) u1 (
    .clk(clk), .rst(rst),
`ifdef DFF_REG_ENABLE_EN
    .en(en1),
`endif
    .d(d1), .q(q1), .q_valid(v1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    rst = 1'b1; d0 = 1'b0; d1 = 8'h00; en0 = 1'b1; en1 = 1'b1;
    #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL reset_q0 got=%b want=0", q0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_v0 got=%b want=0", v0); end
    total++; if (q1 !== 8'hA5) begin bad++; $display("FAIL reset_q1 got=%h want=a5", q1); end
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL reset_v1 got=%b want=0", v1); end
    // edge at t=5 with reset held must not capture
    d0 = 1'b1;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL reset_edge_q0 got=%b want=0", q0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_edge_v0 got=%b want=0", v0); end
    d0 = 1'b0;
    #3; rst = 1'b0;
    #2;
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL deassert_v0 got=%b want=0", v0); end
    @(posedge clk); #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL first_edge_q0 got=%b want=0", q0); end
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL first_edge_v0 got=%b want=1", v0); end
  endtask

  task automatic test_default;
    #4; d0 = 1'b1;
    #4;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL hold_before_q0 got=%b want=0", q0); end
    @(posedge clk); #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL capture1_q0 got=%b want=1", q0); end
    #4; d0 = 1'b0;
    #4;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL hold_between_q0 got=%b want=1", q0); end
    @(posedge clk); #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL capture0_q0 got=%b want=0", q0); end
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL stay_valid_v0 got=%b want=1", v0); end
  endtask

  task automatic test_pipeline;
    rst = 1'b1;
    #1;
    total++; if (q1 !== 8'hA5) begin bad++; $display("FAIL pipe_reset_q1 got=%h want=a5", q1); end
    @(negedge clk); rst = 1'b0; d1 = 8'h01;
    @(posedge clk); #1;
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL pipe_e1 got=%h/%b want=a5/0", q1, v1); end
    @(negedge clk); d1 = 8'h02;
    @(posedge clk); #1;
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL pipe_e2 got=%h/%b want=a5/0", q1, v1); end
    @(negedge clk); d1 = 8'h03;
    @(posedge clk); #1;
    total++; if (q1 !== 8'h01 || v1 !== 1'b1) begin bad++; $display("FAIL pipe_e3 got=%h/%b want=01/1", q1, v1); end
    @(negedge clk); d1 = 8'h04;
    @(posedge clk); #1;
    total++; if (q1 !== 8'h02) begin bad++; $display("FAIL pipe_e4 got=%h want=02", q1); end
    @(posedge clk); #1;
    total++; if (q1 !== 8'h03 || v1 !== 1'b1) begin bad++; $display("FAIL pipe_e5 got=%h/%b want=03/1", q1, v1); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); d0 = 1'b1;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL async_pre_q0 got=%b want=1", q0); end
    #2; rst = 1'b1;
    #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL async_q0 got=%b want=0", q0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL async_v0 got=%b want=0", v0); end
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL async_q1 got=%h/%b want=a5/0", q1, v1); end
  endtask

  task automatic test_mid_fill_reset;
    @(negedge clk); rst = 1'b0; d1 = 8'h11;
    @(negedge clk); d1 = 8'h22;
    @(posedge clk); #1;
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL midfill_pre got=%h/%b want=a5/0", q1, v1); end
    #2; rst = 1'b1;
    #1;
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL midfill_rst got=%h/%b want=a5/0", q1, v1); end
    @(negedge clk); rst = 1'b0; d1 = 8'h33;
    @(posedge clk); #1;
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL refill_e1_v1 got=%b want=0", v1); end
    @(negedge clk); d1 = 8'h44;
    @(posedge clk); #1;
    total++; if (q1 !== 8'hA5 || v1 !== 1'b0) begin bad++; $display("FAIL refill_e2 got=%h/%b want=a5/0", q1, v1); end
    @(negedge clk); d1 = 8'h55;
    @(posedge clk); #1;
    total++; if (q1 !== 8'h33 || v1 !== 1'b1) begin bad++; $display("FAIL refill_e3 got=%h/%b want=33/1", q1, v1); end
  endtask

`ifdef DFF_REG_ENABLE_EN
  task automatic test_enable;
    @(negedge clk); en0 = 1'b1; d0 = 1'b1;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL en_setup_q0 got=%b want=1", q0); end
    @(negedge clk); en0 = 1'b0; d0 = 1'b0;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL en_hold1_q0 got=%b want=1", q0); end
    @(negedge clk); d0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); d0 = 1'b0;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL en_hold2_q0 got=%b want=1", q0); end
    @(negedge clk); en0 = 1'b1;
    @(posedge clk); #1;
    total++; if (q0 !== 1'b0) begin bad++; $display("FAIL en_resume_q0 got=%b want=0", q0); end
    @(negedge clk); rst = 1'b1; en0 = 1'b0;
    #2; rst = 1'b0;
    @(posedge clk); #1;
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL en_valid_hold got=%b want=0", v0); end
    @(negedge clk); en0 = 1'b1;
    @(posedge clk); #1;
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL en_valid_rise got=%b want=1", v0); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_default();
    test_pipeline();
    test_async_reset();
    test_mid_fill_reset();
`ifdef DFF_REG_ENABLE_EN
    test_enable();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
